// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder in front of a word-organised SRAM with programmable wait states.
// Define AHB_SRAM_ERR_EN to add the ERROR response for out-of-range, misaligned or oversized transfers.
module ahb_sram_slave #(
    parameter int unsigned WORD_SIZE   = 32,
    parameter int unsigned ADDR_LENGTH = 32,
    parameter int unsigned MEM_BYTES   = 4096,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   hsel,
    input  logic [ADDR_LENGTH-1:0] haddr,
    input  logic [1:0]             htrans,
    input  logic                   hwrite,
    input  logic [2:0]             hsize,
    input  logic [2:0]             hburst,
    input  logic [3:0]             hprot,
    input  logic [WORD_SIZE-1:0]   hwdata,
    input  logic                   hready,
    output logic                   hreadyout,
    output logic [WORD_SIZE-1:0]   hrdata,
    output logic                   hresp
);

    localparam int unsigned BYTES = WORD_SIZE / 8;
    localparam int unsigned DEPTH = MEM_BYTES / BYTES;
    localparam int unsigned OFF_W = $clog2(MEM_BYTES);
    localparam int unsigned IDX_W = OFF_W - 2;
    localparam int unsigned CNT_W = 3;

`ifdef AHB_SRAM_ERR_EN
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA} state_t;
`endif

    state_t                 state;
    logic [CNT_W-1:0]       wait_cnt;
    logic [ADDR_LENGTH-1:0] addr_r;
    logic                   write_r;
    logic [2:0]             size_r;
    logic [WORD_SIZE-1:0]   mem [DEPTH];

    logic                   accept_c;
    logic                   bad_c;
    logic [ADDR_LENGTH-1:0] off_c;
    logic [IDX_W-1:0]       idx_c;
    logic [BYTES-1:0]       be_c;
    logic                   unused_bits;

    // A new address phase can only be taken while this slave is not stalling the bus
    always_comb begin
        accept_c = 1'b0;
        if (hsel && htrans[1] && hready) begin
            case (state)
                S_IDLE, S_DATA: accept_c = 1'b1;
`ifdef AHB_SRAM_ERR_EN
                S_ERR2:         accept_c = 1'b1;
`endif
                default:        accept_c = 1'b0;
            endcase
        end
    end

`ifdef AHB_SRAM_ERR_EN
    logic [ADDR_LENGTH:0] ext_addr_c;
    logic [ADDR_LENGTH:0] lo_addr_c;
    logic [ADDR_LENGTH:0] hi_addr_c;

    // One extra bit so BASE_ADDR+MEM_BYTES cannot overflow at the top of the map
    assign ext_addr_c = {1'b0, haddr};
    assign lo_addr_c  = (ADDR_LENGTH+1)'(BASE_ADDR);
    assign hi_addr_c  = lo_addr_c + (ADDR_LENGTH+1)'(MEM_BYTES);
    assign bad_c = (ext_addr_c < lo_addr_c) || (ext_addr_c >= hi_addr_c) ||
                   (hsize > 3'd2) ||
                   ((hsize == 3'd1) && haddr[0]) ||
                   ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
`else
    assign bad_c = 1'b0;
`endif

    assign off_c = addr_r - ADDR_LENGTH'(BASE_ADDR);
    assign idx_c = off_c[OFF_W-1:2];

    // Little-endian lane selection; misaligned low bits are aligned down
    always_comb begin
        be_c = '0;
        case (size_r)
            3'd0:    be_c[addr_r[1:0]] = 1'b1;
            3'd1:    be_c = addr_r[1] ? 4'b1100 : 4'b0011;
            default: be_c = 4'b1111;
        endcase
    end

    // Transfer sequencing with registered hreadyout/hresp
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            hreadyout <= 1'b1;
            addr_r    <= '0;
            write_r   <= 1'b0;
            size_r    <= '0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (wait_cnt == CNT_W'(WAIT_STATES - 1)) begin
                        state     <= S_DATA;
                        wait_cnt  <= '0;
                        hreadyout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
`ifdef AHB_SRAM_ERR_EN
                S_ERR1: begin
                    state     <= S_ERR2;
                    hreadyout <= 1'b1;
                end
`endif
                default: begin
                    if (accept_c) begin
                        addr_r  <= haddr;
                        size_r  <= hsize;
                        write_r <= hwrite;
                        if (bad_c) begin
`ifdef AHB_SRAM_ERR_EN
                            state     <= S_ERR1;
                            write_r   <= 1'b0;
                            hreadyout <= 1'b0;
`endif
                        end else if (WAIT_STATES > 0) begin
                            state     <= S_WAIT;
                            hreadyout <= 1'b0;
                        end else begin
                            state     <= S_DATA;
                            hreadyout <= 1'b1;
                        end
                    end else begin
                        state     <= S_IDLE;
                        hreadyout <= 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef AHB_SRAM_ERR_EN
    // hresp tracks entry into and exit from the two-cycle error response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hresp <= 1'b0;
        end else begin
            case (state)
                S_WAIT:  hresp <= 1'b0;
                S_ERR1:  hresp <= 1'b1;
                default: hresp <= accept_c && bad_c;
            endcase
        end
    end
`else
    assign hresp = 1'b0;
`endif

    // Writes commit at the end of the data phase, so a following read already sees them
    always_ff @(posedge clk) begin
        if ((state == S_DATA) && write_r) begin
            for (int b = 0; b < int'(BYTES); b++) begin
                if (be_c[b]) begin
                    mem[idx_c][8*b +: 8] <= hwdata[8*b +: 8];
                end
            end
        end
    end

    assign hrdata = (state == S_DATA) ? mem[idx_c] : '0;

    assign unused_bits = ^{hburst, hprot, htrans[0], off_c[ADDR_LENGTH-1:OFF_W], off_c[1:0]};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: one instance with zero wait states, one with a single wait state.
// Expectations come from a byte-lane memory model; AHB_SRAM_ERR_EN selects the error-response checks.
module tb_ahb_sram_slave;

    localparam int unsigned MEMB = 4096;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsel, hwrite;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic        cur;

    logic        rdy0, rdy1, resp0, resp1;
    logic [31:0] rdata0, rdata1;
    logic        b_rdy, b_resp;
    logic [31:0] b_rdata;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [2][1024];

    always #5 clk = ~clk;

    ahb_sram_slave #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .hsel(hsel & ~cur), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
        .hready(rdy0), .hreadyout(rdy0), .hrdata(rdata0), .hresp(resp0)
    );

    ahb_sram_slave #(.WAIT_STATES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .hsel(hsel & cur), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
        .hready(rdy1), .hreadyout(rdy1), .hrdata(rdata1), .hresp(resp1)
    );

    assign b_rdy   = cur ? rdy1 : rdy0;
    assign b_resp  = cur ? resp1 : resp0;
    assign b_rdata = cur ? rdata1 : rdata0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Byte-lane view of the SRAM: address wraps modulo capacity, size aligns down
    task automatic model_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
        int n, off, idx, start, lane;
        n     = (sz == 3'd0) ? 1 : (sz == 3'd1) ? 2 : 4;
        off   = int'(a % MEMB);
        idx   = off / 4;
        start = (off % 4) - ((off % 4) % n);
        for (int k = 0; k < n; k++) begin
            lane = start + k;
            model[cur][idx][lane*8 +: 8] = wd[lane*8 +: 8];
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return model[cur][int'(a % MEMB) / 4];
    endfunction

    // Single non-pipelined transfer; reports data-phase wait cycles and the first-cycle hresp
    task automatic xfer(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd, output logic rsp,
                        output int waits, output logic rsp_first);
        @(negedge clk);
        hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = wr; hsize = sz;
        @(posedge clk);
        @(negedge clk);
        hsel = 1'b0; htrans = 2'b00; hwdata = wd;
        waits = 0;
        rsp_first = b_resp;
        while (b_rdy !== 1'b1 && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        rd  = b_rdata;
        rsp = b_resp;
    endtask

    task automatic do_write(input string tag, input logic [31:0] a, input logic [2:0] sz,
                            input logic [31:0] wd, input logic check);
        logic [31:0] rd;
        logic        rsp, rf;
        int          w;
        xfer(1'b1, a, sz, wd, rd, rsp, w, rf);
        model_write(a, sz, wd);
        if (check) begin
            chk({tag, "_wait"}, 32'(w), cur ? 32'd1 : 32'd0);
            chk({tag, "_resp"}, 32'(rsp), 32'd0);
        end
    endtask

    task automatic do_read(input string tag, input logic [31:0] a, input logic [2:0] sz);
        logic [31:0] rd;
        logic        rsp, rf;
        int          w;
        xfer(1'b0, a, sz, 32'h0, rd, rsp, w, rf);
        chk({tag, "_data"}, rd, model_read(a));
        chk({tag, "_wait"}, 32'(w), cur ? 32'd1 : 32'd0);
        chk({tag, "_resp"}, 32'(rsp), 32'd0);
    endtask

    initial begin
        logic [31:0] rd, a, wd, wv;
        logic        rsp, rf;
        int          w;
        logic [2:0]  sz;

        rst_n = 1'b0; cur = 1'b1; hsel = 1'b0; htrans = 2'b00; haddr = '0; hwrite = 1'b0;
        hsize = 3'd2; hburst = 3'b001; hprot = 4'b0011; hwdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready0", 32'(rdy0), 32'd1);
        chk("rst_ready1", 32'(rdy1), 32'd1);
        chk("rst_resp",   32'({resp0, resp1}), 32'd0);
        chk("rst_rdata",  rdata1 | rdata0, 32'd0);
        rst_n = 1'b1;

        // Known contents for the first 64 words of both instances
        for (int d = 0; d < 2; d++) begin
            cur = d[0];
            for (int i = 0; i < 64; i++) do_write("init", 32'(i * 4), 3'd2, 32'h0, 1'b0);
        end

        // Wait-state instance: word write/read, then sub-word merge
        cur = 1'b1;
        do_write("t1_wr", 32'h10, 3'd2, 32'hDEAD_BEEF, 1'b1);
        do_read("t1_rd", 32'h10, 3'd2);
        chk("t1_const", model_read(32'h10), 32'hDEAD_BEEF);
        do_write("t2_w0", 32'h20, 3'd2, 32'h0, 1'b1);
        do_write("t2_b",  32'h22, 3'd0, 32'h00AB_0000, 1'b1);
        do_write("t2_h",  32'h20, 3'd1, 32'h0000_1234, 1'b1);
        do_read("t2_rd", 32'h20, 3'd2);
        chk("t2_const", model_read(32'h20), 32'h00AB_1234);

        // Non-transfers must not touch memory or stall
        @(negedge clk); hsel = 1'b1; htrans = 2'b00; haddr = 32'h10; hwrite = 1'b1; hwdata = 32'hFFFF_FFFF;
        @(negedge clk); chk("t4_idle_rdy", 32'(b_rdy), 32'd1);
        htrans = 2'b01;
        @(negedge clk); chk("t4_busy_rdy", 32'(b_rdy), 32'd1);
        hsel = 1'b0; htrans = 2'b10;
        @(negedge clk); chk("t4_nosel_rdy", 32'(b_rdy), 32'd1);
        @(negedge clk); htrans = 2'b00;
        do_read("t4_rd", 32'h10, 3'd2);

        // Zero-wait instance: write, then two back-to-back SEQ reads
        cur = 1'b0;
        wv = $urandom;
        @(negedge clk); hsel = 1'b1; htrans = 2'b10; haddr = 32'h0; hwrite = 1'b1; hsize = 3'd2;
        @(negedge clk);
        chk("t3_wr_rdy", 32'(b_rdy), 32'd1);
        hwdata = wv; htrans = 2'b11; haddr = 32'h4; hwrite = 1'b0;
        model_write(32'h0, 3'd2, wv);
        @(negedge clk);
        chk("t3_rd4_rdy", 32'(b_rdy), 32'd1);
        chk("t3_rd4", b_rdata, model_read(32'h4));
        haddr = 32'h0;
        @(negedge clk);
        chk("t3_rd0_rdy", 32'(b_rdy), 32'd1);
        chk("t3_rd0", b_rdata, wv);
        hsel = 1'b0; htrans = 2'b00;

        // Error response or address aliasing
        cur = 1'b1;
`ifdef AHB_SRAM_ERR_EN
        xfer(1'b0, MEMB, 3'd2, 32'h0, rd, rsp, w, rf);
        chk("t5_oor_first", 32'(rf), 32'd1);
        chk("t5_oor_wait", 32'(w), 32'd1);
        chk("t5_oor_resp", 32'(rsp), 32'd1);
        chk("t5_oor_rdata", rd, 32'd0);
        xfer(1'b1, 32'h3, 3'd2, 32'hCAFE_F00D, rd, rsp, w, rf);
        chk("t5_mis_first", 32'(rf), 32'd1);
        chk("t5_mis_resp", 32'(rsp), 32'd1);
        do_read("t5_unchanged", 32'h0, 3'd2);
`else
        do_read("t5_alias", MEMB, 3'd2);
        do_write("t5_mis", 32'h3, 3'd2, 32'hCAFE_F00D, 1'b1);
        do_read("t5_rd0", 32'h0, 3'd2);
        chk("t5_const", model_read(32'h0), 32'hCAFE_F00D);
`endif

        // Reset during the wait state abandons the write
        do_write("t6_pre", 32'h40, 3'd2, 32'h0000_0055, 1'b1);
        @(negedge clk); hsel = 1'b1; htrans = 2'b10; haddr = 32'h40; hwrite = 1'b1; hsize = 3'd2;
        @(negedge clk); hsel = 1'b0; htrans = 2'b00; hwdata = 32'h0000_00AA;
        chk("t6_wait", 32'(b_rdy), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_rdy", 32'(b_rdy), 32'd1);
        chk("t6_rst_resp", 32'(b_resp), 32'd0);
        chk("t6_rst_rdata", b_rdata, 32'd0);
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        do_read("t6_rd", 32'h40, 3'd2);

        // Randomised aligned traffic on both instances
        for (int d = 0; d < 2; d++) begin
            cur = d[0];
            for (int i = 0; i < 80; i++) begin
                sz = 3'($urandom_range(0, 2));
                a  = 32'($urandom_range(0, 255));
                a  = a & ~((32'd1 << sz) - 32'd1);
                wd = $urandom;
                if ($urandom_range(0, 1) == 0) do_write("rnd_wr", a, sz, wd, 1'b1);
                else                           do_read("rnd_rd", a, sz);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
